evt_txn_collector: RTL and testbench
====================================

Name: evt_txn_collector

Overview:
- Downstream consumer of the value/flag/event stage in the MAC verification environment.
- Samples `val`/`flag` on every event strobe and checks two things:
  - the flag is the even-parity indicator of `val`;
  - successive values increment by exactly one (mod 2^DATA_W).
- Tags each sample and buffers it in a first-word-fall-through FIFO, drained by a ready/valid scoreboard port.
- Keeps saturating trigger and error counters plus sticky status bits for end-of-test reporting.

Parameters:
- DATA_W, 8, width of sampled value.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- CNT_W, 16, width of trigger and error counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of FIFO, counters, stickies and sequence history
- evt_i  in  1  one-cycle event strobe; sample taken when high at the rising edge
- val_i  in  DATA_W  value, valid with evt_i
- flag_i  in  1  flag, valid with evt_i; expected to be 1 iff val_i is even
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry
- out_val  out  DATA_W  head entry value
- out_flag  out  1  head entry flag as received
- out_perr  out  1  head entry parity mismatch tag
- out_serr  out  1  head entry sequence break tag
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- trig_count  out  CNT_W  events accepted (saturating)
- perr_count  out  CNT_W  parity mismatches (saturating)
- seq_err  out  1  sticky: any sequence break seen
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, FIFO empty, first_seen=0, prev_val=0;
  - takes effect immediately, including mid-drain or mid-burst.
- Per event (evt_i=1 at the edge, clear_i=0):
  - trig_count += 1, holding at 2^CNT_W-1.
  - Parity: perr = (flag_i != ~val_i[0]); when perr=1, perr_count += 1 (saturating).
  - Sequence:
    - if first_seen=1 and val_i != prev_val+1 mod 2^DATA_W, then serr=1 and seq_err is set;
    - the first event after reset or clear never flags serr;
    - wrap 2^DATA_W-1 -> 0 is legal.
  - prev_val <= val_i and first_seen <= 1 on every event, whether or not the entry is stored.
- FIFO:
  - Stored entry is {serr, perr, flag_i, val_i}.
  - Pop occurs when out_valid & out_ready; the head advances at that edge.
  - Push occurs when there is an event and either the FIFO is not full, or it is full and a pop happens in the same cycle. In the full-with-pop case the level is unchanged.
  - Full with no pop: the entry is dropped and overflow is set. Counters and sequence checks still update.
  - Empty with an event: push only (out_valid was 0, so no pop).
  - Latency: event at edge N into an empty FIFO gives out_valid=1 and head fields valid after edge N. There is no combinational path from evt_i to the out_* ports.
  - Head fields are undefined-but-stable when out_valid=0. The bench must not check them then.
  - fifo_level updates at the same edge as the push/pop.
  - Read and write pointers use $clog2(DEPTH)+1 bits; wrap is natural.
- clear_i=1 at an edge:
  - empties the FIFO;
  - zeroes trig_count and perr_count;
  - clears seq_err, overflow and first_seen.
- clear_i wins over a simultaneous evt_i or pop: the event is discarded and not counted.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset, then 8 events with val 1..8 and correct flags, out_ready=0:
  - fifo_level=8, trig_count=8, perr_count=0, seq_err=0, overflow=0;
  - then hold out_ready=1 and drain entries 1..8 in order, 8 cycles, all tags 0.
- Continue with a 9th event (val=9) while full, no pop:
  - overflow=1, trig_count=9, fifo_level stays 8;
  - a later event with val=10 does not set seq_err, because prev_val advanced to 9 even though 9 was dropped.
- Events val=254,255,0,1 with correct flags:
  - no serr on the 255->0 wrap;
  - an event with val=5 after 1 gives out_serr=1 on that entry and seq_err=1.
- Event val=3 with flag=1 and event val=4 with flag=0:
  - perr_count=2, both entries out_perr=1;
  - val=6 with flag=1 leaves perr_count=2.
- FIFO full with out_ready=1 and evt_i=1 in the same cycle:
  - fifo_level stays DEPTH, overflow stays 0, the new entry lands at the tail.
- clear_i asserted together with evt_i while 3 entries are held:
  - next cycle fifo_level=0, out_valid=0, trig_count=0, stickies 0;
  - the next event is treated as the first, with no serr.
- Separately, drop rst_n mid-drain: all outputs 0 immediately, before any clock edge.

Source files
------------

// File: rtl/evt_txn_collector.sv
// Event transaction collector: samples val/flag on each event strobe, checks parity and sequence,
// tags each sample and buffers it in a first-word-fall-through FIFO for a ready/valid scoreboard.
module evt_txn_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       evt_i,
  input  logic [DATA_W-1:0]          val_i,
  input  logic                       flag_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_val,
  output logic                       out_flag,
  output logic                       out_perr,
  output logic                       out_serr,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           trig_count,
  output logic [CNT_W-1:0]           perr_count,
  output logic                       seq_err,
  output logic                       overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int ENT_W  = DATA_W + 3;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  trigCnt_q, trigCnt_d;
  logic [CNT_W-1:0]  perrCnt_q, perrCnt_d;
  logic              seqErr_q, seqErr_d;
  logic              overflow_q, overflow_d;
  logic              firstSeen_q, firstSeen_d;
  logic [DATA_W-1:0] prevVal_q, prevVal_d;

  logic [PTR_W-1:0]  level;
  logic              isEmpty, isFull;
  logic              pop, push, memWrite;
  logic              perrNow, serrNow;
  logic [DATA_W-1:0] expectedVal;
  logic [ENT_W-1:0]  newEntry, headEntry;

  assign level       = wrPtr_q - rdPtr_q;
  assign isEmpty     = (level == '0);
  assign isFull      = (level == PTR_W'(DEPTH));
  assign pop         = ~isEmpty & out_ready;
  assign push        = evt_i & (~isFull | pop);
  assign memWrite    = push & ~clear_i;
  assign expectedVal = prevVal_q + DATA_W'(1);
  // Flag should be 1 exactly when the value is even.
  assign perrNow     = (flag_i != ~val_i[0]);
  assign serrNow     = firstSeen_q & (val_i != expectedVal);
  assign newEntry    = {serrNow, perrNow, flag_i, val_i};

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    trigCnt_d   = trigCnt_q;
    perrCnt_d   = perrCnt_q;
    seqErr_d    = seqErr_q;
    overflow_d  = overflow_q;
    firstSeen_d = firstSeen_q;
    prevVal_d   = prevVal_q;
    if (clear_i) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      trigCnt_d   = '0;
      perrCnt_d   = '0;
      seqErr_d    = 1'b0;
      overflow_d  = 1'b0;
      firstSeen_d = 1'b0;
      prevVal_d   = '0;
    end else begin
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (evt_i) begin
        if (trigCnt_q != {CNT_W{1'b1}}) trigCnt_d = trigCnt_q + CNT_W'(1);
        if (perrNow && (perrCnt_q != {CNT_W{1'b1}})) perrCnt_d = perrCnt_q + CNT_W'(1);
        if (serrNow) seqErr_d = 1'b1;
        // Sequence history advances even when the entry itself is dropped.
        prevVal_d   = val_i;
        firstSeen_d = 1'b1;
        if (push) begin
          wrPtr_d = wrPtr_q + PTR_W'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      trigCnt_q   <= '0;
      perrCnt_q   <= '0;
      seqErr_q    <= 1'b0;
      overflow_q  <= 1'b0;
      firstSeen_q <= 1'b0;
      prevVal_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      trigCnt_q   <= trigCnt_d;
      perrCnt_q   <= perrCnt_d;
      seqErr_q    <= seqErr_d;
      overflow_q  <= overflow_d;
      firstSeen_q <= firstSeen_d;
      prevVal_q   <= prevVal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem_q[wrPtr_q[ADDR_W-1:0]] <= newEntry;
    end
  end

  // Head fields are forced to zero while empty so reset leaves every output at 0.
  assign headEntry  = mem_q[rdPtr_q[ADDR_W-1:0]];
  assign out_valid  = ~isEmpty;
  assign out_val    = out_valid ? headEntry[DATA_W-1:0] : '0;
  assign out_flag   = out_valid & headEntry[DATA_W];
  assign out_perr   = out_valid & headEntry[DATA_W+1];
  assign out_serr   = out_valid & headEntry[DATA_W+2];
  assign fifo_level = level;
  assign trig_count = trigCnt_q;
  assign perr_count = perrCnt_q;
  assign seq_err    = seqErr_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_evt_txn_collector.sv
// Directed self-checking bench for evt_txn_collector (DATA_W=8, DEPTH=8, CNT_W=16).
module tb_evt_txn_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_i;
  logic        evt_i;
  logic [7:0]  val_i;
  logic        flag_i;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_val;
  logic        out_flag;
  logic        out_perr;
  logic        out_serr;
  logic [3:0]  fifo_level;
  logic [15:0] trig_count;
  logic [15:0] perr_count;
  logic        seq_err;
  logic        overflow;

  int compareCount = 0;
  int failCount    = 0;

  evt_txn_collector #(.DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .evt_i     (evt_i),
    .val_i     (val_i),
    .flag_i    (flag_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_flag  (out_flag),
    .out_perr  (out_perr),
    .out_serr  (out_serr),
    .fifo_level(fifo_level),
    .trig_count(trig_count),
    .perr_count(perr_count),
    .seq_err   (seq_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic goodFlag(input logic [7:0] v);
    return ~v[0];
  endfunction

  // One clock with the given event inputs; inputs change #1 after the edge.
  task automatic applyStimulus(input logic evt, input logic [7:0] val, input logic flag, input logic clr);
    evt_i   = evt;
    val_i   = val;
    flag_i  = flag;
    clear_i = clr;
    @(posedge clk);
    #1;
    evt_i   = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [7:0] val, input logic flag,
                          input logic perr, input logic serr);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".val"},   32'(out_val),   32'(val));
    checkOutput({tag, ".flag"},  32'(out_flag),  32'(flag));
    checkOutput({tag, ".perr"},  32'(out_perr),  32'(perr));
    checkOutput({tag, ".serr"},  32'(out_serr),  32'(serr));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"}, 32'(out_valid),  32'd0);
    checkOutput({tag, ".val"},   32'(out_val),    32'd0);
    checkOutput({tag, ".flag"},  32'(out_flag),   32'd0);
    checkOutput({tag, ".perr"},  32'(out_perr),   32'd0);
    checkOutput({tag, ".serr"},  32'(out_serr),   32'd0);
    checkOutput({tag, ".level"}, 32'(fifo_level), 32'd0);
    checkOutput({tag, ".trig"},  32'(trig_count), 32'd0);
    checkOutput({tag, ".pcnt"},  32'(perr_count), 32'd0);
    checkOutput({tag, ".seq"},   32'(seq_err),    32'd0);
    checkOutput({tag, ".ovf"},   32'(overflow),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; evt_i = 1'b0; val_i = '0; flag_i = 1'b0; out_ready = 1'b0;
    #12;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill with 1..8, then one more event while full with no pop.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), goodFlag(8'(i)), 1'b0);
    checkOutput("fill.level", 32'(fifo_level), 32'd8);
    checkOutput("fill.trig",  32'(trig_count), 32'd8);
    checkOutput("fill.pcnt",  32'(perr_count), 32'd0);
    checkOutput("fill.seq",   32'(seq_err),    32'd0);
    checkOutput("fill.ovf",   32'(overflow),   32'd0);
    applyStimulus(1'b1, 8'd9, goodFlag(8'd9), 1'b0);
    checkOutput("ovf.flag",  32'(overflow),   32'd1);
    checkOutput("ovf.trig",  32'(trig_count), 32'd9);
    checkOutput("ovf.level", 32'(fifo_level), 32'd8);
    for (int i = 1; i <= 8; i++) popCheck($sformatf("drain%0d", i), 8'(i), goodFlag(8'(i)), 1'b0, 1'b0);
    checkOutput("drained.level", 32'(fifo_level), 32'd0);
    checkOutput("drained.valid", 32'(out_valid),  32'd0);
    applyStimulus(1'b1, 8'd10, goodFlag(8'd10), 1'b0);
    checkOutput("after9.seq", 32'(seq_err), 32'd0);
    popCheck("after9", 8'd10, 1'b1, 1'b0, 1'b0);

    // Clear, then the 255->0 wrap is legal and a jump 1->5 flags serr.
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("clr1.ovf",  32'(overflow),   32'd0);
    checkOutput("clr1.trig", 32'(trig_count), 32'd0);
    applyStimulus(1'b1, 8'd254, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd255, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd0,   1'b1, 1'b0);
    applyStimulus(1'b1, 8'd1,   1'b0, 1'b0);
    checkOutput("wrap.seq",  32'(seq_err),    32'd0);
    checkOutput("wrap.trig", 32'(trig_count), 32'd4);
    popCheck("wrap254", 8'd254, 1'b1, 1'b0, 1'b0);
    popCheck("wrap255", 8'd255, 1'b0, 1'b0, 1'b0);
    popCheck("wrap0",   8'd0,   1'b1, 1'b0, 1'b0);
    popCheck("wrap1",   8'd1,   1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
    checkOutput("jump.seq", 32'(seq_err), 32'd1);
    popCheck("jump5", 8'd5, 1'b0, 1'b0, 1'b1);

    // Parity errors: 3 with flag 1, 4 with flag 0; 6 with flag 1 is correct.
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
    checkOutput("par.pcnt", 32'(perr_count), 32'd2);
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b0);
    checkOutput("par6.pcnt", 32'(perr_count), 32'd2);
    popCheck("par3", 8'd3, 1'b1, 1'b1, 1'b1);
    popCheck("par4", 8'd4, 1'b0, 1'b1, 1'b0);
    popCheck("par6", 8'd6, 1'b1, 1'b0, 1'b1);

    // Full FIFO with simultaneous pop and push keeps its level.
    for (int i = 7; i <= 14; i++) applyStimulus(1'b1, 8'(i), goodFlag(8'(i)), 1'b0);
    checkOutput("full2.level", 32'(fifo_level), 32'd8);
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'd15, goodFlag(8'd15), 1'b0);
    out_ready = 1'b0;
    checkOutput("pp.level", 32'(fifo_level), 32'd8);
    checkOutput("pp.ovf",   32'(overflow),   32'd0);
    checkOutput("pp.trig",  32'(trig_count), 32'd17);
    for (int i = 8; i <= 15; i++) popCheck($sformatf("pp%0d", i), 8'(i), goodFlag(8'(i)), 1'b0, 1'b0);

    // Clear together with an event while 3 entries are held.
    for (int i = 16; i <= 18; i++) applyStimulus(1'b1, 8'(i), goodFlag(8'(i)), 1'b0);
    checkOutput("hold3.level", 32'(fifo_level), 32'd3);
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b1);
    checkAllZero("clr2");
    applyStimulus(1'b1, 8'd77, 1'b0, 1'b0);
    checkOutput("first.seq",  32'(seq_err),    32'd0);
    checkOutput("first.trig", 32'(trig_count), 32'd1);
    popCheck("first77", 8'd77, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 78; i <= 80; i++) applyStimulus(1'b1, 8'(i), goodFlag(8'(i)), 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("middrain.level", 32'(fifo_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncrst");
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
